// File: rtl/div_sqrt_mant_engine_pkg.sv
// Shared constants, state encoding and helpers for the radix-2 div/sqrt mantissa engine.
// Rounding-mode encodings live here so the downstream rounding stage shares one definition.
package div_sqrt_mant_engine_pkg;

  localparam int C_DIV_MANT  = 23;
  localparam int C_QBITS     = C_DIV_MANT + 3;
  localparam int C_CNT_W     = 5;
  localparam int C_REM_W     = C_QBITS + 3;     // holds the wider sqrt remainder
  localparam int C_DIV_REM_W = C_DIV_MANT + 4;  // signed division remainder
  localparam int C_RAD_W     = 2 * C_QBITS;     // zero-padded radicand

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DIV    = 2'b01,
    ST_SQRT   = 2'b10,
    ST_FINISH = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } round_mode_t;

  // Radicand bit pair consumed at a given step, most significant pair first.
  function automatic logic [1:0] rad_pair(input logic [C_DIV_MANT+1:0] mant,
                                          input logic [C_CNT_W-1:0]    step);
    logic [C_RAD_W-1:0] rad;
    rad = {mant, {(C_RAD_W-C_DIV_MANT-2){1'b0}}};
    rad = rad << {step, 1'b0};
    return rad[C_RAD_W-1 -: 2];
  endfunction

endpackage

// File: rtl/div_sqrt_mant_engine_mant_iter_step.sv
// Single combinational iteration: one non-restoring division step or one restoring
// square-root step, producing the next remainder, the result bit and a sticky hint.
module mant_iter_step
  import div_sqrt_mant_engine_pkg::*;
(
  input  logic                  mode_sqrt,
  input  logic                  first_step,
  input  logic [C_REM_W-1:0]    rem_cur,
  input  logic [C_DIV_MANT:0]   divisor,
  input  logic [1:0]            pair,
  input  logic [C_QBITS-1:0]    root_cur,
  output logic [C_REM_W-1:0]    rem_next,
  output logic                  q_bit,
  output logic                  rem_nz
);

  localparam int C_SQ_W = C_REM_W + 3;

  logic [C_DIV_REM_W-1:0] d_rem;
  logic [C_DIV_REM_W-1:0] d_shift;
  logic [C_DIV_REM_W-1:0] d_b;
  logic [C_DIV_REM_W-1:0] d_next;
  logic [C_DIV_REM_W-1:0] d_fix;
  logic [C_SQ_W-1:0]      s_base;
  logic [C_SQ_W-1:0]      s_sub;
  logic [C_SQ_W-1:0]      s_trial;
  logic [C_SQ_W-1:0]      s_next;
  logic                   s_ok;

  // Division: the first step subtracts B from the unshifted dividend.
  assign d_rem   = rem_cur[C_DIV_REM_W-1:0];
  assign d_b     = {{(C_DIV_REM_W-C_DIV_MANT-1){1'b0}}, divisor};
  assign d_shift = first_step ? d_rem : {d_rem[C_DIV_REM_W-2:0], 1'b0};
  assign d_next  = d_rem[C_DIV_REM_W-1] ? (d_shift + d_b) : (d_shift - d_b);
  // A negative final remainder stands for R+B in restoring terms.
  assign d_fix   = d_next + d_b;

  assign s_base  = {1'b0, rem_cur, pair};
  assign s_sub   = {{(C_SQ_W-C_QBITS-2){1'b0}}, root_cur, 2'b01};
  assign s_trial = s_base - s_sub;
  assign s_ok    = ~s_trial[C_SQ_W-1];
  assign s_next  = s_ok ? s_trial : s_base;

  always_comb begin
    rem_next = '0;
    q_bit    = 1'b0;
    rem_nz   = 1'b0;
    if (mode_sqrt) begin
      rem_next = s_next[C_REM_W-1:0];
      q_bit    = s_ok;
      rem_nz   = |s_next[C_REM_W-1:0];
    end else begin
      rem_next = {{(C_REM_W-C_DIV_REM_W){d_next[C_DIV_REM_W-1]}}, d_next};
      q_bit    = ~d_next[C_DIV_REM_W-1];
      rem_nz   = d_next[C_DIV_REM_W-1] ? (|d_fix) : (|d_next);
    end
  end

endmodule

// File: rtl/div_sqrt_mant_engine.sv
// Sequencer for the div/sqrt mantissa engine: handshake, iteration counter, remainder
// and partial-result registers; the arithmetic lives in mant_iter_step.
module div_sqrt_mant_engine
  import div_sqrt_mant_engine_pkg::*;
(
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  Div_start_SI,
  input  logic                  Sqrt_start_SI,
  input  logic                  Kill_SI,
  input  logic [C_DIV_MANT+1:0] Mant_a_DI,
  input  logic [C_DIV_MANT:0]   Mant_b_DI,
  output logic                  Ready_SO,
  output logic                  Done_SO,
  output logic [C_QBITS-1:0]    Quot_DO,
  output logic                  Sticky_DO
);

  state_t                state_reg, state_next;
  logic [C_CNT_W-1:0]    cnt_reg;
  logic [C_REM_W-1:0]    rem_reg;
  logic [C_QBITS-1:0]    q_reg;
  logic [C_DIV_MANT+1:0] a_reg;
  logic [C_DIV_MANT:0]   b_reg;
  logic [C_QBITS-1:0]    quot_reg;
  logic                  sticky_reg;

  logic                  start_div;
  logic                  start_sqrt;
  logic                  step_en;
  logic                  finish_load;
  logic                  last_step;
  logic [C_REM_W-1:0]    rem_next;
  logic                  q_bit;
  logic                  rem_nz;

  assign last_step = (cnt_reg == C_CNT_W'(C_QBITS-1));

  always_comb begin
    state_next  = state_reg;
    start_div   = 1'b0;
    start_sqrt  = 1'b0;
    step_en     = 1'b0;
    finish_load = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (Div_start_SI) begin
          state_next = ST_DIV;
          start_div  = 1'b1;
        end else if (Sqrt_start_SI) begin
          state_next = ST_SQRT;
          start_sqrt = 1'b1;
        end
      end
      ST_DIV, ST_SQRT: begin
        step_en = 1'b1;
        if (last_step) begin
          state_next  = ST_FINISH;
          finish_load = 1'b1;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    // Abort wins over starts, steps and the result update.
    if (Kill_SI) begin
      state_next  = ST_IDLE;
      start_div   = 1'b0;
      start_sqrt  = 1'b0;
      step_en     = 1'b0;
      finish_load = 1'b0;
    end
  end

  mant_iter_step u_step (
    .mode_sqrt  (state_reg == ST_SQRT),
    .first_step (cnt_reg == '0),
    .rem_cur    (rem_reg),
    .divisor    (b_reg),
    .pair       (rad_pair(a_reg, cnt_reg)),
    .root_cur   (q_reg),
    .rem_next   (rem_next),
    .q_bit      (q_bit),
    .rem_nz     (rem_nz)
  );

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      cnt_reg <= '0;
      rem_reg <= '0;
      q_reg   <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
    end else if (start_div || start_sqrt) begin
      cnt_reg <= '0;
      q_reg   <= '0;
      a_reg   <= Mant_a_DI;
      b_reg   <= Mant_b_DI;
      rem_reg <= start_div ? {{(C_REM_W-C_DIV_MANT-2){1'b0}}, Mant_a_DI} : '0;
    end else if (step_en) begin
      cnt_reg <= cnt_reg + C_CNT_W'(1);
      rem_reg <= rem_next;
      q_reg   <= {q_reg[C_QBITS-2:0], q_bit};
    end
  end

  // Results are captured on the last step so they are valid alongside Done_SO.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      quot_reg   <= '0;
      sticky_reg <= 1'b0;
    end else if (finish_load) begin
      quot_reg   <= {q_reg[C_QBITS-2:0], q_bit};
      sticky_reg <= rem_nz;
    end
  end

  assign Ready_SO  = (state_reg == ST_IDLE);
  assign Done_SO   = (state_reg == ST_FINISH);
  assign Quot_DO   = quot_reg;
  assign Sticky_DO = sticky_reg;

endmodule

// File: tb/tb_div_sqrt_mant_engine.sv
// Self-checking bench for div_sqrt_mant_engine: directed table, random ops against an
// arithmetic reference, and hand-written kill/reset/handshake sequences.
module tb_div_sqrt_mant_engine;
  import div_sqrt_mant_engine_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  div_start = 1'b0;
  logic                  sqrt_start = 1'b0;
  logic                  kill = 1'b0;
  logic [C_DIV_MANT+1:0] mant_a = '0;
  logic [C_DIV_MANT:0]   mant_b = '0;
  logic                  ready;
  logic                  done;
  logic [C_QBITS-1:0]    quot;
  logic                  sticky;

  int                    chk_cnt = 0;
  int                    pass_cnt = 0;
  int                    op_cnt = 0;
  logic [C_QBITS-1:0]    prev_q = '0;
  logic                  prev_s = 1'b0;

  typedef struct {
    string                 name;
    bit                    is_div;
    logic [C_DIV_MANT+1:0] a;
    logic [C_DIV_MANT:0]   b;
    logic [C_QBITS-1:0]    exp_q;
    bit                    exp_s;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  div_sqrt_mant_engine dut (
    .Clk_CI        (clk),
    .Rst_RBI       (rst_n),
    .Div_start_SI  (div_start),
    .Sqrt_start_SI (sqrt_start),
    .Kill_SI       (kill),
    .Mant_a_DI     (mant_a),
    .Mant_b_DI     (mant_b),
    .Ready_SO      (ready),
    .Done_SO       (done),
    .Quot_DO       (quot),
    .Sticky_DO     (sticky)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Quotient = floor(A*2^25/B); root = floor(sqrt(A*2^27)); sticky = inexact.
  function automatic void ref_model(input bit is_div, input logic [C_DIV_MANT+1:0] a,
                                    input logic [C_DIV_MANT:0] b,
                                    output logic [C_QBITS-1:0] q, output bit s);
    longint unsigned n, r, lo, hi, mid;
    if (is_div) begin
      n = longint'(a) << (C_QBITS - 1);
      r = n / longint'(b);
      q = r[C_QBITS-1:0];
      s = (n % longint'(b)) != 0;
    end else begin
      n  = longint'(a) << (2 * (C_QBITS - 1) - C_DIV_MANT);
      lo = 0;
      hi = (longint'(1) << C_QBITS) - 1;
      while (lo < hi) begin
        mid = (lo + hi + 1) >> 1;
        if (mid * mid <= n) lo = mid;
        else hi = mid - 1;
      end
      q = lo[C_QBITS-1:0];
      s = (lo * lo) != n;
    end
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      chk_cnt++;
      $display("FAIL wait_ready: ready=%0d required 1", ready);
    end
  endtask

  // Starts an op at a negedge and watches it; bounded at 40 cycles.
  task automatic run_op(input bit sd, input bit ss, input logic [C_DIV_MANT+1:0] a,
                        input logic [C_DIV_MANT:0] b, input int kill_at, input bit spam,
                        output int lat, output int dones, output logic rdy1,
                        output logic [C_QBITS-1:0] mid_q, output logic rdy_k);
    div_start  = sd;
    sqrt_start = ss;
    mant_a     = a;
    mant_b     = b;
    lat = 0; dones = 0; rdy1 = 1'bx; mid_q = 'x; rdy_k = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (lat == 0) lat = n;
      end
      if (n == 1) rdy1 = ready;
      if (n == 10) mid_q = quot;
      if (kill_at != 0 && n == kill_at + 1) rdy_k = ready;
      div_start = 1'b0; sqrt_start = 1'b0; kill = 1'b0;
      if (spam && n >= 3 && n <= 20) begin
        div_start  = 1'b1;
        sqrt_start = n[0];
        mant_a     = C_DIV_MANT'($urandom);
        mant_b     = (C_DIV_MANT+1)'($urandom);
      end
      if (n == kill_at) kill = 1'b1;
      if (lat != 0 && kill_at == 0 && !spam) break;
    end
  endtask

  task automatic do_checked(input string tag, input bit sd, input bit ss,
                            input logic [C_DIV_MANT+1:0] a, input logic [C_DIV_MANT:0] b,
                            input logic [C_QBITS-1:0] exp_q, input bit exp_s);
    int lat, dones;
    logic rdy1, rdy_k;
    logic [C_QBITS-1:0] mid_q;
    wait_ready();
    run_op(sd, ss, a, b, 0, 0, lat, dones, rdy1, mid_q, rdy_k);
    check({tag, " latency"}, 64'(lat), 64'(C_QBITS + 1));
    check({tag, " ready_low"}, 64'(rdy1), 64'(0));
    check({tag, " quot_hold"}, 64'(mid_q), 64'(prev_q));
    check({tag, " quot"}, 64'(quot), 64'(exp_q));
    check({tag, " sticky"}, 64'(sticky), 64'(exp_s));
    $display("op %0d %s %s a=%h b=%h quot=%h sticky=%0d exp=%h/%0d", op_cnt, tag,
             sd ? "div" : "sqrt", a, b, quot, sticky, exp_q, exp_s);
    op_cnt++;
    prev_q = exp_q;
    prev_s = exp_s;
  endtask

  initial begin
    int lat, dones;
    logic rdy1, rdy_k;
    logic [C_QBITS-1:0] mid_q, eq;
    bit es, isd;
    logic [C_DIV_MANT+1:0] ra;
    logic [C_DIV_MANT:0] rb;

    vecs[0] = '{"div 1/1",      1'b1, 25'h0800000, 24'h800000, 26'h2000000, 1'b0};
    vecs[1] = '{"div 1/1.5",    1'b1, 25'h0800000, 24'hC00000, 26'h1555555, 1'b1};
    vecs[2] = '{"sqrt 2.25",    1'b0, 25'h1200000, 24'h000000, 26'h3000000, 1'b0};
    vecs[3] = '{"sqrt 1",       1'b0, 25'h0800000, 24'h000000, 26'h2000000, 1'b0};
    vecs[4] = '{"div max/1",    1'b1, 25'h0FFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0};
    vecs[5] = '{"div 1/max",    1'b1, 25'h0800000, 24'hFFFFFF, 26'h1000001, 1'b1};
    vecs[6] = '{"sqrt 1.5625",  1'b0, 25'h0C80000, 24'h000000, 26'h2800000, 1'b0};

    #1;
    check("reset ready", 64'(ready), 64'(1));
    check("reset done", 64'(done), 64'(0));
    check("reset quot", 64'(quot), 64'(0));
    check("reset sticky", 64'(sticky), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      do_checked(vecs[i].name, vecs[i].is_div, !vecs[i].is_div, vecs[i].a, vecs[i].b,
                 vecs[i].exp_q, vecs[i].exp_s);

    @(negedge clk);
    check("post done low", 64'(done), 64'(0));
    check("post ready high", 64'(ready), 64'(1));

    // Kill in cycle 10 of a division.
    run_op(1'b1, 1'b0, 25'h0800000, 24'hC00000, 10, 1'b0, lat, dones, rdy1, mid_q, rdy_k);
    check("kill no done", 64'(dones), 64'(0));
    check("kill ready", 64'(rdy_k), 64'(1));
    check("kill quot kept", 64'(quot), 64'(prev_q));
    check("kill sticky kept", 64'(sticky), 64'(prev_s));
    $display("op %0d kill div at cycle 10 dones=%0d quot=%h", op_cnt, dones, quot);
    op_cnt++;

    // Both starts high: division wins.
    do_checked("both starts", 1'b1, 1'b1, 25'h0800000, 24'hC00000, 26'h1555555, 1'b1);

    // Start pulses while busy are ignored.
    wait_ready();
    run_op(1'b0, 1'b1, 25'h1200000, 24'h0, 0, 1'b1, lat, dones, rdy1, mid_q, rdy_k);
    check("busy single done", 64'(dones), 64'(1));
    check("busy latency", 64'(lat), 64'(C_QBITS + 1));
    check("busy quot", 64'(quot), 64'(26'h3000000));
    check("busy sticky", 64'(sticky), 64'(0));
    $display("op %0d sqrt with busy starts dones=%0d quot=%h", op_cnt, dones, quot);
    op_cnt++;
    prev_q = 26'h3000000;
    prev_s = 1'b0;

    // Kill together with a start in IDLE drops the start.
    wait_ready();
    kill = 1'b1;
    div_start = 1'b1;
    mant_a = 25'h0800000;
    mant_b = 24'h800000;
    @(negedge clk);
    kill = 1'b0;
    div_start = 1'b0;
    check("kill+start ready", 64'(ready), 64'(1));
    @(negedge clk);
    check("kill+start ready2", 64'(ready), 64'(1));
    $display("op %0d kill with start in idle ready=%0d", op_cnt, ready);
    op_cnt++;

    for (int i = 0; i < 30; i++) begin
      isd = 1'($urandom_range(0, 1));
      if (isd) begin
        ra = {2'b01, 23'($urandom)};
        rb = {1'b1, 23'($urandom)};
      end else begin
        ra = 25'($urandom_range(2**23, 2**25 - 1));
        rb = 24'($urandom);
      end
      ref_model(isd, ra, rb, eq, es);
      do_checked("random", isd, !isd, ra, rb, eq, es);
    end

    // Asynchronous reset in the middle of a square root.
    wait_ready();
    sqrt_start = 1'b1;
    mant_a = 25'h1200000;
    @(negedge clk);
    sqrt_start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset ready", 64'(ready), 64'(1));
    check("midreset done", 64'(done), 64'(0));
    check("midreset quot", 64'(quot), 64'(0));
    check("midreset sticky", 64'(sticky), 64'(0));
    $display("op %0d reset during sqrt quot=%h", op_cnt, quot);
    op_cnt++;
    prev_q = '0;
    prev_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_checked("after reset", 1'b1, 1'b0, 25'h0800000, 24'hC00000, 26'h1555555, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
